// File: rtl/audio_pkg.sv
// Shared definitions for the audio IIR filter slice.
// Holds the default sample/coefficient widths and the filter state encoding
// so the top level and any future siblings agree on them.
package audio_pkg;

   localparam int DefaultDataWidth  = 12;
   localparam int DefaultCoeffWidth = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DIFF   = 2'd1,
      MULT   = 2'd2,
      UPDATE = 2'd3
   } filter_state_e;

endpackage

// File: rtl/shift_add_multiplier.sv
// Serial shift-and-add multiplier: signed multiplicand times unsigned multiplier,
// one multiplier bit per clock, least significant bit first.
// Ports:
//   clk, reset    - system clock, synchronous active-high reset
//   start         - one-cycle pulse: latch operands, clear accumulator and bit counter
//   multiplicand  - signed operand (MultiplicandWidth bits)
//   multiplier    - unsigned operand (MultiplierWidth bits)
//   product       - signed accumulator, full width, valid the cycle after done
//   done          - high during the cycle the last partial product is being added
module shift_add_multiplier #(
   parameter int MultiplicandWidth = 13,
   parameter int MultiplierWidth   = 8
) (
   input  logic                                               clk,
   input  logic                                               reset,
   input  logic                                               start,
   input  logic signed [MultiplicandWidth-1:0]                multiplicand,
   input  logic        [MultiplierWidth-1:0]                  multiplier,
   output logic signed [MultiplicandWidth+MultiplierWidth-1:0] product,
   output logic                                               done
);

   localparam int ProductWidth = MultiplicandWidth + MultiplierWidth;
   localparam int CountWidth   = (MultiplierWidth > 1) ? $clog2(MultiplierWidth) : 1;
   localparam logic [CountWidth-1:0] LastBit = CountWidth'(MultiplierWidth - 1);

   logic signed [ProductWidth-1:0] acc;
   logic signed [ProductWidth-1:0] mcand_shift;
   logic        [MultiplierWidth-1:0] mplier_shift;
   logic        [CountWidth-1:0] bit_cnt;
   logic                         running;

   // The multiplicand is pre-shifted one place per cycle so bit i of the
   // multiplier always pairs with multiplicand << i without a barrel shifter.
   always_ff @(posedge clk) begin
      if (reset) begin
         acc          <= '0;
         mcand_shift  <= '0;
         mplier_shift <= '0;
         bit_cnt      <= '0;
         running      <= 1'b0;
      end else if (start) begin
         acc          <= '0;
         mcand_shift  <= {{MultiplierWidth{multiplicand[MultiplicandWidth-1]}}, multiplicand};
         mplier_shift <= multiplier;
         bit_cnt      <= '0;
         running      <= 1'b1;
      end else if (running) begin
         if (mplier_shift[0]) begin
            acc <= acc + mcand_shift;
         end
         mcand_shift  <= mcand_shift <<< 1;
         mplier_shift <= mplier_shift >> 1;
         bit_cnt      <= bit_cnt + 1'b1;
         if (bit_cnt == LastBit) begin
            running <= 1'b0;
         end
      end
   end

   assign product = acc;
   assign done    = running && (bit_cnt == LastBit);

endmodule

// File: rtl/audio_iir_filter.sv
// One-pole low-pass audio filter between the ADC and DAC sides of an I2S
// controller: y = yPrev + ((alpha * (x - yPrev)) >>> CoeffWidth), saturated.
// Ports:
//   clk, reset    - system clock, synchronous active-high reset
//   coeff         - alpha, unsigned Q0.CoeffWidth, captured on accept
//   bypass        - pass the sample straight through, captured on accept
//   clearOverrun  - clears the sticky overrun flag
//   inData/inValid   - incoming signed sample and its one-cycle strobe
//   outData/outValid - filtered signed sample and its one-cycle strobe
//   busy          - high whenever a sample is being processed
//   overrun       - sticky: a sample arrived while busy and was dropped
module audio_iir_filter
   import audio_pkg::*;
#(
   parameter int DataWidth  = DefaultDataWidth,
   parameter int CoeffWidth = DefaultCoeffWidth
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic        [CoeffWidth-1:0] coeff,
   input  logic                        bypass,
   input  logic                        clearOverrun,
   input  logic signed [DataWidth-1:0] inData,
   input  logic                        inValid,
   output logic signed [DataWidth-1:0] outData,
   output logic                        outValid,
   output logic                        busy,
   output logic                        overrun
);

   localparam int ProductWidth = DataWidth + 1 + CoeffWidth;
   localparam logic signed [ProductWidth-1:0] SatMax = ProductWidth'((2 ** (DataWidth - 1)) - 1);
   localparam logic signed [ProductWidth-1:0] SatMin = ProductWidth'(-(2 ** (DataWidth - 1)));

   filter_state_e state;

   logic signed [DataWidth-1:0]    x_reg;
   logic signed [DataWidth-1:0]    y_prev;
   logic        [CoeffWidth-1:0]   alpha_reg;
   logic                           bypass_reg;

   logic signed [DataWidth:0]      diff;
   logic                           mult_start;
   logic signed [ProductWidth-1:0] product;
   logic                           mult_done;
   logic signed [ProductWidth-1:0] shifted;
   logic signed [ProductWidth-1:0] sum;
   logic signed [DataWidth-1:0]    filtered;
   logic signed [DataWidth-1:0]    next_y;

   // One extra bit keeps x - yPrev exact for full-scale inputs of opposite sign.
   assign diff = {x_reg[DataWidth-1], x_reg} - {y_prev[DataWidth-1], y_prev};

   // The multiplier latches diff and clears itself during DIFF.
   assign mult_start = (state == DIFF);

   shift_add_multiplier #(
      .MultiplicandWidth(DataWidth + 1),
      .MultiplierWidth  (CoeffWidth)
   ) u_mult (
      .clk         (clk),
      .reset       (reset),
      .start       (mult_start),
      .multiplicand(diff),
      .multiplier  (alpha_reg),
      .product     (product),
      .done        (mult_done)
   );

   // Arithmetic shift floors toward negative infinity; no rounding is applied.
   assign shifted = product >>> CoeffWidth;
   assign sum     = {{(CoeffWidth + 1){y_prev[DataWidth-1]}}, y_prev} + shifted;

   // Clamp the sum into the signed sample range before it becomes state.
   always_comb begin
      filtered = sum[DataWidth-1:0];
      if (sum > SatMax) begin
         filtered = {1'b0, {(DataWidth - 1){1'b1}}};
      end else if (sum < SatMin) begin
         filtered = {1'b1, {(DataWidth - 1){1'b0}}};
      end
   end

   assign next_y = bypass_reg ? x_reg : filtered;

   // Sequencer: IDLE accepts a sample, DIFF launches the multiply, MULT waits
   // out the serial bits, UPDATE commits the result. outValid is registered so
   // it pulses in the cycle after UPDATE, when the state is already IDLE again.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         x_reg      <= '0;
         y_prev     <= '0;
         alpha_reg  <= '0;
         bypass_reg <= 1'b0;
         outData    <= '0;
         outValid   <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         outValid <= 1'b0;
         case (state)
            IDLE: begin
               if (inValid) begin
                  x_reg      <= inData;
                  alpha_reg  <= coeff;
                  bypass_reg <= bypass;
                  state      <= DIFF;
               end
            end
            DIFF: begin
               state <= MULT;
            end
            MULT: begin
               if (mult_done) begin
                  state <= UPDATE;
               end
            end
            UPDATE: begin
               y_prev   <= next_y;
               outData  <= next_y;
               outValid <= 1'b1;
               state    <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase

         // A drop in the same cycle as a clear wins, so no drop goes unreported.
         if (inValid && (state != IDLE)) begin
            overrun <= 1'b1;
         end else if (clearOverrun) begin
            overrun <= 1'b0;
         end
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_audio_iir_filter.sv
// Directed testbench for audio_iir_filter with an expected-output scoreboard.
// Expected samples are queued when a sample is driven and compared when the
// filter pulses outValid; latency, pulse width, busy and overrun are also checked.
module tb_audio_iir_filter;

   logic               clk = 1'b0;
   logic               reset;
   logic        [7:0]  coeff;
   logic               bypass;
   logic               clearOverrun;
   logic signed [11:0] inData;
   logic               inValid;
   logic signed [11:0] outData;
   logic               outValid;
   logic               busy;
   logic               overrun;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int t_accept = 0;
   int model_y  = 0;
   int exp_q[$];

   audio_iir_filter dut (
      .clk         (clk),
      .reset       (reset),
      .coeff       (coeff),
      .bypass      (bypass),
      .clearOverrun(clearOverrun),
      .inData      (inData),
      .inValid     (inValid),
      .outData     (outData),
      .outValid    (outValid),
      .busy        (busy),
      .overrun     (overrun)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkVal(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, $signed(observed), $signed(expected));
      end
   endtask

   // Independent reference: floor division written out explicitly.
   function automatic int modelStep(input int x, input int a, input bit byp);
      int p;
      int q;
      int y;
      if (byp) return x;
      p = a * (x - model_y);
      if (p >= 0) q = p / 256;
      else        q = -((-p + 255) / 256);
      y = model_y + q;
      if (y > 2047)  y = 2047;
      if (y < -2048) y = -2048;
      return y;
   endfunction

   // Called at a negedge; drives a one-cycle inValid pulse and returns at the next negedge.
   task automatic applyStimulus(input int x, input int a, input bit byp, input bit expect_out, input int expected);
      inData   = 12'(x);
      coeff    = 8'(a);
      bypass   = byp;
      inValid  = 1'b1;
      t_accept = cyc;
      if (expect_out) begin
         exp_q.push_back(expected);
         model_y = expected;
      end
      @(negedge clk);
      inValid = 1'b0;
   endtask

   task automatic dropPulse(input bit with_clear);
      inData       = 12'sd77;
      coeff        = 8'd200;
      bypass       = 1'b1;
      inValid      = 1'b1;
      clearOverrun = with_clear;
      @(negedge clk);
      inValid      = 1'b0;
      clearOverrun = 1'b0;
   endtask

   task automatic waitUntil(input int offset);
      while (cyc < t_accept + offset) @(negedge clk);
   endtask

   // Called at the negedge of a cycle in which outValid should be high.
   task automatic checkPulseHere(input string tag);
      int expected;
      checkVal({tag, "_valid"}, outValid, 1);
      checkVal({tag, "_latency"}, cyc - t_accept, 11);
      if (exp_q.size() == 0) begin
         checkVal({tag, "_scoreboard_empty"}, 1, 0);
      end else begin
         expected = exp_q.pop_front();
         checkVal({tag, "_data"}, outData, expected);
      end
   endtask

   task automatic checkOutput(input string tag);
      int   waited;
      bit   found;
      logic signed [11:0] held;
      waited = 0;
      found  = 1'b0;
      while (!found && waited < 40) begin
         @(posedge clk);
         #1;
         if (outValid) found = 1'b1;
         waited++;
      end
      if (!found) begin
         checkVal({tag, "_timeout"}, 0, 1);
         @(negedge clk);
      end else begin
         @(negedge clk);
         checkPulseHere(tag);
         held = outData;
         @(negedge clk);
         checkVal({tag, "_pulse_width"}, outValid, 0);
         checkVal({tag, "_hold"}, outData, held);
         checkVal({tag, "_idle"}, busy, 0);
      end
   endtask

   task automatic watchQuiet(input string tag, input int n);
      int pulses;
      logic signed [11:0] held;
      pulses = 0;
      held   = outData;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (outValid) pulses++;
      end
      checkVal({tag, "_no_pulse"}, pulses, 0);
      checkVal({tag, "_hold"}, outData, held);
   endtask

   initial begin
      reset        = 1'b1;
      coeff        = '0;
      bypass       = 1'b0;
      clearOverrun = 1'b0;
      inData       = '0;
      inValid      = 1'b0;

      // Reset release: everything at zero, and quiet without input.
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checkVal("rst_outData", outData, 0);
      checkVal("rst_outValid", outValid, 0);
      checkVal("rst_busy", busy, 0);
      checkVal("rst_overrun", overrun, 0);
      watchQuiet("rst_quiet", 20);
      checkVal("rst_quiet_zero", outData, 0);

      // Half-way steps toward 1000.
      applyStimulus(1000, 128, 1'b0, 1'b1, 500);
      checkVal("busy_after_accept", busy, 1);
      checkOutput("half_1");
      applyStimulus(1000, 128, 1'b0, 1'b1, 750);
      checkOutput("half_2");

      // Floor behaviour and large positive step from full negative scale.
      applyStimulus(0, 0, 1'b1, 1'b1, 0);
      checkOutput("bypass_zero");
      applyStimulus(-1, 1, 1'b0, 1'b1, -1);
      checkOutput("floor_neg");
      applyStimulus(-2048, 0, 1'b1, 1'b1, -2048);
      checkOutput("bypass_min_a");
      applyStimulus(2047, 255, 1'b0, 1'b1, 2031);
      checkOutput("alpha_255");

      // Bypass, then alpha=0 holds the state.
      applyStimulus(-2048, 5, 1'b1, 1'b1, -2048);
      checkOutput("bypass_min_b");
      applyStimulus(2047, 0, 1'b0, 1'b1, -2048);
      checkOutput("alpha_zero");

      // Further patterns against the reference model.
      applyStimulus(-1500, 77, 1'b0, 1'b1, modelStep(-1500, 77, 1'b0));
      checkOutput("model_1");
      applyStimulus(300, 200, 1'b0, 1'b1, modelStep(300, 200, 1'b0));
      checkOutput("model_2");
      applyStimulus(-1000, 3, 1'b0, 1'b1, modelStep(-1000, 3, 1'b0));
      checkOutput("model_3");

      // Drop while in MULT: one result only, sticky overrun, then clear.
      applyStimulus(1000, 128, 1'b0, 1'b1, modelStep(1000, 128, 1'b0));
      waitUntil(5);
      checkVal("ovr_before", overrun, 0);
      dropPulse(1'b0);
      checkVal("ovr_set", overrun, 1);
      checkVal("ovr_busy", busy, 1);
      checkOutput("ovr_result");
      watchQuiet("ovr_single", 20);
      checkVal("ovr_sticky", overrun, 1);
      clearOverrun = 1'b1;
      @(negedge clk);
      clearOverrun = 1'b0;
      checkVal("ovr_cleared", overrun, 0);

      // Drop in the UPDATE cycle with a simultaneous clear: overrun stays set.
      applyStimulus(-800, 64, 1'b0, 1'b1, modelStep(-800, 64, 1'b0));
      waitUntil(10);
      checkVal("upd_busy", busy, 1);
      dropPulse(1'b1);
      checkVal("upd_ovr", overrun, 1);
      checkPulseHere("upd_result");
      watchQuiet("upd_single", 20);
      clearOverrun = 1'b1;
      @(negedge clk);
      clearOverrun = 1'b0;
      checkVal("upd_cleared", overrun, 0);

      // A sample arriving while outValid is high is accepted.
      applyStimulus(600, 128, 1'b0, 1'b1, modelStep(600, 128, 1'b0));
      waitUntil(11);
      checkPulseHere("b2b_first");
      applyStimulus(-600, 200, 1'b0, 1'b1, modelStep(-600, 200, 1'b0));
      checkOutput("b2b_second");
      checkVal("b2b_no_overrun", overrun, 0);

      // Reset mid-computation aborts it and clears the filter state.
      applyStimulus(500, 128, 1'b0, 1'b0, 0);
      waitUntil(5);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      model_y = 0;
      checkVal("abort_busy", busy, 0);
      checkVal("abort_outData", outData, 0);
      checkVal("abort_outValid", outValid, 0);
      watchQuiet("abort_quiet", 20);
      applyStimulus(100, 128, 1'b0, 1'b1, 50);
      checkOutput("after_abort");

      checkVal("scoreboard_drained", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/audio_iir_filter.md
AUDIO_IIR_FILTER -- requirements
Module: audio_iir_filter

Interface
REQ-001 SHALL have parameter DataWidth, default 12, giving the signed sample width in and out.
REQ-002 SHALL have parameter CoeffWidth, default 8, giving the unsigned Q0.CoeffWidth filter coefficient width.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock. All logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port coeff, input, CoeffWidth bits: alpha, captured when a sample is accepted.
REQ-006 SHALL have port bypass, input, 1 bit: pass the sample through unfiltered; captured when a sample is accepted.
REQ-007 SHALL have port clearOverrun, input, 1 bit: clears the overrun flag.
REQ-008 SHALL have port inData, input, DataWidth bits, signed: the sample from the ADC side of the I2S controller.
REQ-009 SHALL have port inValid, input, 1 bit: a single-cycle pulse marking inData valid.
REQ-010 SHALL have port outData, output, DataWidth bits, signed: the filtered sample to the DAC side of the I2S controller.
REQ-011 SHALL have port outValid, output, 1 bit: a single-cycle pulse marking outData valid.
REQ-012 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-013 SHALL have port overrun, output, 1 bit: sticky flag recording a sample dropped while busy.

Function
REQ-014 SHALL compute the one-pole low-pass y = yPrev + ((alpha*(x - yPrev)) >>> CoeffWidth), where yPrev is an internal state register.
REQ-015 SHALL form the difference as a DataWidth+1-bit signed value and the product as a DataWidth+1+CoeffWidth-bit signed value, with alpha zero-extended.
REQ-016 SHALL perform the shift by CoeffWidth as an arithmetic shift (floor toward negative infinity), with no rounding.
REQ-017 SHALL saturate the sum to [-2^(DataWidth-1), 2^(DataWidth-1)-1] before it is written to yPrev and outData.
REQ-018 SHALL use the states IDLE, DIFF, MULT and UPDATE; encoding is implementation's choice.
REQ-019 SHALL, in IDLE with inValid=1, capture inData, coeff and bypass and go to DIFF on the next cycle; call this accept cycle T.
REQ-020 SHALL, in DIFF, compute the difference, clear the accumulator and bit counter, and go to MULT.
REQ-021 SHALL, in MULT, spend exactly CoeffWidth cycles; at bit i, add diff<<i to the accumulator when alpha[i]=1; after the last bit go to UPDATE.
REQ-022 SHALL, in UPDATE, write yPrev and outData, go to IDLE, and assert outValid in the following cycle.
REQ-023 SHALL make outValid high for exactly one cycle, in cycle T+CoeffWidth+3 (cycle T+11 at defaults).
REQ-024 SHALL hold outData stable between outValid pulses.
REQ-025 SHALL, when the captured bypass=1, set outData = x and yPrev = x with the same latency.
REQ-026 SHALL leave yPrev unchanged when alpha=0, so outData repeats yPrev.
REQ-027 SHALL, on inValid=1 while busy (including the UPDATE cycle), drop the sample, leave the in-flight computation unaffected and set overrun.
REQ-028 SHALL clear overrun on clearOverrun=1 unless a drop occurs in the same cycle, in which case overrun stays set.
REQ-029 SHALL accept inValid in the cycle outValid is high, since the state is IDLE then.

Reset
REQ-030 SHALL, on reset, force state=IDLE, yPrev=0, accumulator=0, outData=0, outValid=0, busy=0 and overrun=0.
REQ-031 SHALL, on reset asserted mid-computation, abort the computation with no outValid pulse, both in that cycle and afterwards.

Structure
REQ-032 SHALL place DataWidth and CoeffWidth defaults and the state enum typedef in shared package audio_pkg.
REQ-033 SHALL implement the serial multiply in sub-module shift_add_multiplier, with start/done handshake, signed multiplicand and unsigned multiplier.

Verification
REQ-034 SHALL cover reset release: all outputs 0; no outValid within 20 cycles without inValid.
REQ-035 SHALL cover alpha=128, yPrev=0, x=1000: outData=500 at T+11; a second x=1000 gives 750.
REQ-036 SHALL cover alpha=1, yPrev=0, x=-1: outData=-1 (floor check); then alpha=255, yPrev=-2048, x=2047 gives 2031.
REQ-037 SHALL cover bypass=1, x=-2048: outData=-2048; then bypass=0, alpha=0, x=2047 gives outData=-2048.
REQ-038 SHALL cover inValid at T and T+5: one outValid only, overrun=1 from T+6; clearOverrun gives overrun=0 next cycle.
REQ-039 SHALL cover reset at T+5: no outValid; next x=100, alpha=128 gives 50, proving yPrev=0.
